// File: rtl/swipt_pkg.sv
// swipt_data_tx shared definitions.
// Frame constants, FSM states and the word bit encoder.
package swipt_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LATCH,
    ST_PRE,
    ST_WORD,
    ST_GAP,
    ST_DONE
  } state_t;

  localparam logic [7:0] PREAMBLE = 8'hAA;
  localparam int WORD_BITS = 23;
  localparam int PREAMBLE_BITS = 8;
  localparam logic [1:0] PROG_DATA = 2'b11;
  localparam int NUM_TELEMETRY_WORDS = 9;

  // start, index, data, even parity, stop; b=0 is sent first
  function automatic logic word_bit(
    input logic [3:0]  idx,
    input logic [15:0] data,
    input logic [4:0]  b
  );
    logic [22:0] w;
    w = {1'b1, idx, data, ^{idx, data}, 1'b0};
    return w[5'd22 - b];
  endfunction

endpackage

// File: rtl/swipt_bit_timer.sv
// Loadable down-counter shared by bit and gap timing.
// tick is high for the single cycle the loaded count expires.
module swipt_bit_timer #(
  parameter int W = 10
) (
  input  logic         clk,
  input  logic         nrst,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic         tick
);

  logic [W-1:0] cnt;
  logic         armed;

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      cnt   <= '0;
      armed <= 1'b0;
    end else if (load) begin
      cnt   <= load_val;
      armed <= 1'b1;
    end else if (armed) begin
      if (cnt == '0) armed <= 1'b0;
      else           cnt   <= cnt - 1'b1;
    end
  end

  assign tick = armed & (cnt == '0);

endmodule

// File: rtl/swipt_data_tx.sv
// Serial telemetry transmitter: snapshots nine words and sends
// them as a preamble plus framed, bit-timed words on write/dout/read.
module swipt_data_tx
  import swipt_pkg::*;
#(
  parameter int BIT_CYCLES = 1000,
  parameter int GAP_CYCLES = 200,
  parameter int NUM_WORDS  = NUM_TELEMETRY_WORDS
) (
  input  logic         clk,
  input  logic         nrst,
  input  logic         swiptAlive,
  input  logic [1:0]   prog,
  input  logic         start,
  input  logic [143:0] word_in,
  output logic         write,
  output logic         dout,
  output logic         read,
  output logic         busy,
  output logic         done,
  output logic         abort
);

  localparam int MAXC = (BIT_CYCLES > GAP_CYCLES) ?
                        BIT_CYCLES : GAP_CYCLES;
  localparam int TW = $clog2(MAXC + 1);
  localparam logic [TW-1:0] BIT_LD = TW'(BIT_CYCLES - 1);
  localparam logic [TW-1:0] GAP_LD =
    (GAP_CYCLES > 0) ? TW'(GAP_CYCLES - 1) : '0;
  localparam logic [3:0] LAST_WORD = 4'(NUM_WORDS - 1);
  localparam logic [4:0] LAST_PRE  = 5'(PREAMBLE_BITS - 1);
  localparam logic [4:0] LAST_BIT  = 5'(WORD_BITS - 1);

  state_t        state, state_n;
  logic [3:0]    word_idx, word_n;
  logic [4:0]    bit_idx, bit_n;
  logic          read_q, read_n;
  logic          abort_q, abort_n;
  logic          snap_ld;
  logic          tload, tick;
  logic [TW-1:0] tval;
  logic          ok;
  logic [15:0]   snap [NUM_WORDS];

  assign ok = swiptAlive & (prog == PROG_DATA);

  swipt_bit_timer #(.W(TW)) u_timer (
    .clk      (clk),
    .nrst     (nrst),
    .load     (tload),
    .load_val (tval),
    .tick     (tick)
  );

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state    <= ST_IDLE;
      word_idx <= '0;
      bit_idx  <= '0;
      read_q   <= 1'b0;
      abort_q  <= 1'b0;
      for (int k = 0; k < NUM_WORDS; k++) snap[k] <= '0;
    end else begin
      state    <= state_n;
      word_idx <= word_n;
      bit_idx  <= bit_n;
      read_q   <= read_n;
      abort_q  <= abort_n;
      if (snap_ld)
        for (int k = 0; k < NUM_WORDS; k++)
          snap[k] <= word_in[16*k +: 16];
    end
  end

  always_comb begin
    state_n = state;
    word_n  = word_idx;
    bit_n   = bit_idx;
    read_n  = 1'b0;
    abort_n = 1'b0;
    snap_ld = 1'b0;
    tload   = 1'b0;
    tval    = BIT_LD;
    if (state inside {ST_LATCH, ST_PRE, ST_WORD, ST_GAP} && !ok) begin
      state_n = ST_IDLE;
      abort_n = 1'b1;
    end else begin
      case (state)
        ST_IDLE:
          if (start && ok) state_n = ST_LATCH;
        ST_LATCH: begin
          snap_ld = 1'b1;
          state_n = ST_PRE;
          word_n  = '0;
          bit_n   = '0;
          tload   = 1'b1;
          read_n  = 1'b1;
        end
        ST_PRE:
          if (tick) begin
            tload  = 1'b1;
            read_n = 1'b1;
            if (bit_idx == LAST_PRE) begin
              state_n = ST_WORD;
              bit_n   = '0;
            end else begin
              bit_n = bit_idx + 1'b1;
            end
          end
        ST_WORD:
          if (tick) begin
            if (bit_idx != LAST_BIT) begin
              bit_n  = bit_idx + 1'b1;
              tload  = 1'b1;
              read_n = 1'b1;
            end else if (word_idx == LAST_WORD) begin
              state_n = ST_DONE;
            end else begin
              word_n = word_idx + 1'b1;
              bit_n  = '0;
              tload  = 1'b1;
              // a zero-length gap goes straight into the next word
              if (GAP_CYCLES > 0) begin
                state_n = ST_GAP;
                tval    = GAP_LD;
              end else begin
                read_n = 1'b1;
              end
            end
          end
        ST_GAP:
          if (tick) begin
            state_n = ST_WORD;
            tload   = 1'b1;
            read_n  = 1'b1;
          end
        ST_DONE:
          state_n = ST_IDLE;
        default:
          state_n = ST_IDLE;
      endcase
    end
  end

  always_comb begin
    dout = 1'b0;
    case (state)
      ST_PRE:  dout = PREAMBLE[3'd7 - bit_idx[2:0]];
      ST_WORD: dout = word_bit(word_idx, snap[word_idx], bit_idx);
      default: dout = 1'b0;
    endcase
  end

  assign write = (state == ST_PRE) | (state == ST_WORD) |
                 (state == ST_GAP);
  assign read  = read_q;
  assign busy  = (state != ST_IDLE);
  assign done  = (state == ST_DONE);
  assign abort = abort_q;

endmodule

// File: tb/tb_swipt_data_tx.sv
// Directed bench for swipt_data_tx with BIT_CYCLES=4, GAP_CYCLES=2.
// Bits are captured on read strobes and compared with hand-built words.
module tb_swipt_data_tx;

  localparam int BC = 4;
  localparam int GC = 2;

  logic         clk = 1'b0;
  logic         nrst = 1'b0;
  logic         swiptAlive = 1'b0;
  logic [1:0]   prog = 2'b00;
  logic         start = 1'b0;
  logic [143:0] word_in = '0;
  logic         write, dout, read, busy, done, abort;

  swipt_data_tx #(
    .BIT_CYCLES (BC),
    .GAP_CYCLES (GC),
    .NUM_WORDS  (9)
  ) dut (
    .clk        (clk),
    .nrst       (nrst),
    .swiptAlive (swiptAlive),
    .prog       (prog),
    .start      (start),
    .word_in    (word_in),
    .write      (write),
    .dout       (dout),
    .read       (read),
    .busy       (busy),
    .done       (done),
    .abort      (abort)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  logic bits [$];
  int   rt [$];
  int   wcnt = 0, dcnt = 0, dfall = 0, acnt = 0;
  logic pw = 1'b0;

  always @(negedge clk) begin
    if (read) begin
      bits.push_back(dout);
      rt.push_back(cyc);
    end
    if (write) wcnt++;
    if (done) begin
      dcnt++;
      if (pw && !write) dfall++;
    end
    if (abort) acnt++;
    pw = write;
  end

  int errs = 0;
  int checks = 0;

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic logic [63:0] get(input int base, input int n);
    logic [63:0] v = '0;
    for (int i = 0; i < n; i++)
      v = {v[62:0], (base + i < bits.size()) ? bits[base + i] : 1'bx};
    return v;
  endfunction

  task automatic pulse_start();
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
  endtask

  task automatic wait_done(input int lim, input int d0);
    int n = 0;
    while (dcnt == d0 && n < lim) begin
      @(posedge clk);
      n++;
    end
    chk("done_timeout", 64'(dcnt != d0), 64'd1);
  endtask

  task automatic wait_bits(input int target, input int lim);
    int n = 0;
    while (bits.size() < target && n < lim) begin
      @(posedge clk);
      n++;
    end
    chk("bits_timeout", 64'(bits.size() >= target), 64'd1);
  endtask

  typedef struct {
    logic [15:0] data;
    logic [22:0] exp;
  } vec_t;

  vec_t tbl [9];
  int b0, b1, w0, d0, f0, a0, bad;

  initial begin
    tbl[0] = '{16'h9999, 23'b1_0000_1001100110011001_0_0};
    tbl[1] = '{16'h0000, 23'b1_0001_0000000000000000_1_0};
    tbl[2] = '{16'hFFFF, 23'b1_0010_1111111111111111_1_0};
    tbl[3] = '{16'h1234, 23'b1_0011_0001001000110100_1_0};
    tbl[4] = '{16'h8001, 23'b1_0100_1000000000000001_1_0};
    tbl[5] = '{16'h0000, 23'b1_0101_0000000000000000_0_0};
    tbl[6] = '{16'hABCD, 23'b1_0110_1010101111001101_0_0};
    tbl[7] = '{16'h0001, 23'b1_0111_0000000000000001_0_0};
    tbl[8] = '{16'h00FF, 23'b1_1000_0000000011111111_1_0};

    prog = 2'b11;
    swiptAlive = 1'b1;
    repeat (3) @(posedge clk);
    #1 chk("reset_outs", 64'({write, dout, read, busy, done, abort}), 64'd0);
    nrst = 1'b1;

    // nominal frame, all words 9999, plus a start while busy
    word_in = {9{16'h9999}};
    b0 = bits.size(); w0 = wcnt; d0 = dcnt; f0 = dfall;
    pulse_start();
    @(negedge clk); #1 chk("latch_write_low", 64'(write), 64'd0);
    @(negedge clk); #1 chk("first_bit", 64'({write, read, dout, busy}), 64'hF);
    repeat (40) @(posedge clk);
    #1 chk("busy_mid", 64'(busy), 64'd1);
    pulse_start();
    wait_done(1200, d0);
    repeat (5) @(posedge clk);
    chk("write_len", 64'(wcnt - w0), 64'd876);
    chk("read_count", 64'(bits.size() - b0), 64'd215);
    chk("done_count", 64'(dcnt - d0), 64'd1);
    chk("done_at_fall", 64'(dfall - f0), 64'd1);
    chk("idle_after", 64'({busy, write}), 64'd0);
    bad = 0;
    for (int i = 1; i < 215 && b0 + i < rt.size(); i++) begin
      int d;
      d = (i >= 31 && (i - 8) % 23 == 0) ? 6 : 4;
      if (rt[b0 + i] - rt[b0 + i - 1] != d) bad++;
    end
    chk("strobe_spacing", 64'(bad), 64'd0);
    chk("nom_word0", get(b0 + 8, 23), 64'(23'b1_0000_1001100110011001_0_0));
    chk("nom_word8", get(b0 + 8 + 23 * 8, 23),
        64'(23'b1_1000_1001100110011001_1_0));

    // gated start
    prog = 2'b10;
    w0 = wcnt;
    pulse_start();
    repeat (5) @(posedge clk);
    chk("gated_write", 64'(wcnt - w0), 64'd0);
    chk("gated_busy", 64'(busy), 64'd0);
    prog = 2'b11;

    // encoding frame with snapshot change during word 1
    for (int k = 0; k < 9; k++) word_in[16*k +: 16] = tbl[k].data;
    b0 = bits.size(); d0 = dcnt;
    pulse_start();
    wait_bits(b0 + 8 + 23 + 5, 300);
    word_in[80 +: 16] = 16'hFFFF;
    wait_done(1200, d0);
    chk("preamble", get(b0, 8), 64'hAA);
    for (int k = 0; k < 9; k++)
      chk($sformatf("word%0d", k), get(b0 + 8 + 23 * k, 23), 64'(tbl[k].exp));

    // abort during word 4
    b0 = bits.size(); d0 = dcnt; a0 = acnt;
    pulse_start();
    wait_bits(b0 + 8 + 23 * 4 + 3, 800);
    #1 swiptAlive = 1'b0;
    @(posedge clk);
    @(negedge clk);
    #1 chk("abort_cycle", 64'({write, dout, busy, done, abort}), 64'd1);
    swiptAlive = 1'b1;
    b1 = bits.size();
    @(posedge clk);
    #1 chk("abort_one_cycle", 64'(abort), 64'd0);
    start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    chk("abort_count", 64'(acnt - a0), 64'd1);
    chk("abort_no_done", 64'(dcnt - d0), 64'd0);
    wait_bits(b1 + 8, 100);
    chk("restart_preamble", get(b1, 8), 64'hAA);

    // async reset mid-bit
    @(posedge clk);
    #2 nrst = 1'b0;
    #1 chk("async_reset", 64'({write, dout, read, busy, done, abort}), 64'd0);
    @(posedge clk);
    #1 nrst = 1'b1;
    w0 = wcnt; a0 = acnt; d0 = dcnt;
    repeat (10) @(posedge clk);
    chk("post_reset_idle", 64'({busy, 1'b0}) | 64'(wcnt - w0), 64'd0);
    chk("post_reset_pulses", 64'((acnt - a0) + (dcnt - d0)), 64'd0);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
